instr_enc: RTL and testbench
============================

# instr_enc

- Pipelined RISC-V instruction encoder: accepts an immediate, its format code and register/funct fields, and produces the packed 32-bit instruction word.
- Exact inverse of the datapath immediate extender, using the same `imm_src` codes.
- Used by the debug/self-test path to build instructions for injection into the multi-cycle core.
- Two register stages with valid/ready on both sides; optional immediate range checking; an error counter.

## Interface
- `CNT_W`, default 8: width of the saturating error counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when high with `in_valid`.
- `in_imm_src` in 3: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 reserved.
- `in_imm` in 32: immediate as a signed byte offset or value. For U, this is the final value with low 12 bits zero.
- `in_opcode` in 7, `in_rd` in 5, `in_rs1` in 5, `in_rs2` in 5, `in_funct3` in 3: raw instruction fields.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: downstream accepts.
- `out_instr` out 32: encoded instruction.
- `out_err` out 1: immediate out of range, misaligned, or reserved `imm_src`. Qualified by `out_valid`.
- `err_cnt` out `CNT_W`: count of errored words delivered, saturating.

## Operation
- **Field placement per format** (`opcode` always in [6:0]):
  - I: imm[11:0]→[31:20], rs1→[19:15], funct3→[14:12], rd→[11:7].
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
  - B: field value v = in_imm + 4 (33-bit add). The datapath subtracts 4 when decoding B, so this add is required.
    - Placement: v[12]→[31], v[10:5]→[30:25], rs2, rs1, funct3, v[4:1]→[11:8], v[11]→[7].
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12], rd.
  - U: imm[31:12]→[31:12], rd.
- **Reserved `imm_src`:** `out_instr` = 0, `out_err` = 1.
- **Stage S1:** registers the raw request.
- **Stage S2:** registers the packed word and error flag.
- **Per-stage behaviour:** each stage is a valid register that loads when it is empty or when the stage after it is advancing (bubble collapse).
- **`in_ready`:** equals !s1_valid | !s2_valid | out_ready. This is a combinational path from `out_ready`.
- **`err_cnt`:** increments on out_valid & out_ready & out_err; holds at all-ones.
- **Ordering and throughput:** order is strictly preserved, nothing is dropped or duplicated, and while `out_ready` is high the block accepts one request per cycle.

## Timing
- **Reset values:** s1_valid=0, s2_valid=0, `out_valid`=0, `out_instr`=0, `out_err`=0, `err_cnt`=0, `in_ready`=1.
- **Latency:** a request accepted at edge N shows `out_valid`=1 after edge N+1 (two cycles).
- **Stall:** when `out_ready` is low, `out_instr` and `out_err` hold stable.
- **Buffering:** both stages full with `out_ready` low forces `in_ready` low. At most two requests are buffered.
- **Simultaneous input and output handshakes in one cycle:** both complete, and occupancy is unchanged.
- **Reset asserted mid-stream:** all in-flight requests are discarded immediately, with no partial output.

## Configuration
- **`INSTR_ENC_RANGE_CHECK_EN` defined**, `out_err` is set when:
  - I/S: in_imm is outside [-2048, 2047].
  - B: in_imm is odd, or in_imm+4 is outside [-4096, 4094].
  - J: in_imm is odd or outside [-2^20, 2^20-2].
  - U: in_imm[11:0] ≠ 0.
  - Reserved `imm_src`, as above.
  - An errored word is still packed (truncated bits) and delivered.
- **Undefined:** only reserved `imm_src` sets `out_err`. Immediates are silently truncated and the check logic is absent.

## Structure
- **Package `riscv_imm_pkg`:** `IMM_I`/`IMM_S`/`IMM_B`/`IMM_J`/`IMM_U` codes, `B_PC_ADJ`=4, and I/S/B/J range limits.
- **Sub-module `imm_pack`:** purely combinational. Inputs are the fields plus `imm_src`; outputs are the word and the error flag. It sits between S1 and S2.

## Test plan
- I: `imm_src`=000, imm=0xFFFFFFFF, opcode=0x13, rd=5, rs1=6, funct3=0 → `out_instr`=0xFFF30293, `out_err`=0, two cycles after acceptance.
- S: `imm_src`=001, imm=8, opcode=0x23, rs1=3, rs2=2, funct3=2 → 0x0021A423.
- B: `imm_src`=010, imm=-4, opcode=0x63, rs1=rs2=0, funct3=0 → 0x00000063.
- U: imm=0x12345000, opcode=0x37, rd=1 → 0x123450B7.
  - With the macro, imm=0x12345001 → `out_err`=1 and `err_cnt` 0→1.
  - Without the macro → `out_err`=0.
- Backpressure and reset:
  - Three back-to-back requests with `out_ready`=0 → `in_ready` drops after two are held. Raising `out_ready` delivers all three in order with no loss.
  - Asserting `rst_n`=0 mid-stream → `out_valid`=0 and `err_cnt`=0 immediately.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// Immediate format codes and encodable ranges shared by the immediate
// extender and the instruction encoder.
package riscv_imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // The extender subtracts this on B decode, so the encoder adds it back.
  localparam int B_PC_ADJ = 4;

  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;
  localparam int J_MIN  = -(1 << 20);
  localparam int J_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: places immediate and register fields into a 32-bit word.
// Range checking is built only when INSTR_ENC_RANGE_CHECK_EN is defined.
module imm_pack
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  output logic [31:0] instr,
  output logic        err
);

  // Bits [12:1] of (imm + B_PC_ADJ); bit 0 is never placed, so add the halves.
  logic [11:0] b_half;
  logic        range_err;

  assign b_half = imm[12:1] + 12'(B_PC_ADJ / 2);

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [32:0] imm_s;
  logic signed [32:0] b_s;

  assign imm_s = $signed({imm[31], imm});
  assign b_s   = imm_s + $signed(33'(B_PC_ADJ));

  always_comb begin
    range_err = 1'b0;
    unique case (imm_src)
      IMM_I, IMM_S: range_err = (imm_s < $signed(33'(IS_MIN))) || (imm_s > $signed(33'(IS_MAX)));
      IMM_B:        range_err = imm[0] || (b_s < $signed(33'(B_MIN))) ||
                                (b_s > $signed(33'(B_MAX)));
      IMM_J:        range_err = imm[0] || (imm_s < $signed(33'(J_MIN))) ||
                                (imm_s > $signed(33'(J_MAX)));
      IMM_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    instr = '0;
    err   = 1'b0;
    unique case (imm_src)
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = range_err;
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = range_err;
      end
      IMM_B: begin
        instr = {b_half[11], b_half[9:4], rs2, rs1, funct3, b_half[3:0], b_half[10], opcode};
        err   = range_err;
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = range_err;
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = range_err;
      end
      default: begin
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_enc.sv
// Two-stage valid/ready RISC-V instruction encoder with a saturating error counter.
// Optional immediate range checking: define INSTR_ENC_RANGE_CHECK_EN.
module instr_enc
  import riscv_imm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_src,
  input  logic [31:0]      in_imm,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic             s1_valid_q;
  logic [2:0]       s1_imm_src_q;
  logic [31:0]      s1_imm_q;
  logic [6:0]       s1_opcode_q;
  logic [4:0]       s1_rd_q;
  logic [4:0]       s1_rs1_q;
  logic [4:0]       s1_rs2_q;
  logic [2:0]       s1_funct3_q;
  logic             s2_valid_q;
  logic [31:0]      s2_instr_q;
  logic             s2_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [31:0]      pack_instr;
  logic             pack_err;
  logic             s1_ready;
  logic             s2_ready;

  // Each stage loads when empty or when the stage after it advances.
  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;

  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_imm_src_q <= '0;
      s1_imm_q     <= '0;
      s1_opcode_q  <= '0;
      s1_rd_q      <= '0;
      s1_rs1_q     <= '0;
      s1_rs2_q     <= '0;
      s1_funct3_q  <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_imm_src_q <= in_imm_src;
        s1_imm_q     <= in_imm;
        s1_opcode_q  <= in_opcode;
        s1_rd_q      <= in_rd;
        s1_rs1_q     <= in_rs1;
        s1_rs2_q     <= in_rs2;
        s1_funct3_q  <= in_funct3;
      end
    end
  end

  imm_pack u_imm_pack (
    .imm_src (s1_imm_src_q),
    .imm     (s1_imm_q),
    .opcode  (s1_opcode_q),
    .rd      (s1_rd_q),
    .rs1     (s1_rs1_q),
    .rs2     (s1_rs2_q),
    .funct3  (s1_funct3_q),
    .instr   (pack_instr),
    .err     (pack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= pack_instr;
        s2_err_q   <= pack_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed format vectors, backpressure,
// randomized stream against an arithmetic reference model, and mid-stream reset.
module tb_instr_enc;

  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_imm_src;
  logic [31:0]   in_imm;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  instr_enc #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm_src (in_imm_src),
    .in_imm     (in_imm),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder built from bit arithmetic on the immediate value.
  function automatic exp_t model_enc(input logic [2:0] src, input logic [31:0] imm,
                                     input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3);
    exp_t   r;
    longint s;
    longint v;
    longint base_r;
    longint base_s;
    longint w;
    s      = longint'($signed(imm));
    v      = s + 4;
    base_r = (longint'(rs1) << 15) | (longint'(f3) << 12) | (longint'(rd) << 7) | longint'(op);
    base_s = (longint'(rs2) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) |
             longint'(op);
    r.e = 1'b0;
    w   = 0;
    case (src)
      3'd0: begin
        w = ((s & 'hFFF) << 20) | base_r;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        r.e = (s < -2048) || (s > 2047);
`endif
      end
      3'd1: begin
        w = (((s >> 5) & 'h7F) << 25) | ((s & 'h1F) << 7) | base_s;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        r.e = (s < -2048) || (s > 2047);
`endif
      end
      3'd2: begin
        w = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) | (((v >> 1) & 'hF) << 8) |
            (((v >> 11) & 1) << 7) | base_s;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        r.e = ((s & 1) != 0) || (v < -4096) || (v > 4094);
`endif
      end
      3'd3: begin
        w = (((s >> 20) & 1) << 31) | (((s >> 1) & 'h3FF) << 21) | (((s >> 11) & 1) << 20) |
            (((s >> 12) & 'hFF) << 12) | (longint'(rd) << 7) | longint'(op);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        r.e = ((s & 1) != 0) || (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2);
`endif
      end
      3'd4: begin
        w = (s & 'hFFFFF000) | (longint'(rd) << 7) | longint'(op);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        r.e = (s & 'hFFF) != 0;
`endif
      end
      default: begin
        w   = 0;
        r.e = 1'b1;
      end
    endcase
    r.w = w[31:0];
    return r;
  endfunction

  function automatic int sat_inc(input int c, input logic e);
    return (e && c < CNT_MAX) ? c + 1 : c;
  endfunction

  task automatic set_req(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3);
    in_imm_src = src;
    in_imm     = imm;
    in_opcode  = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_funct3  = f3;
  endtask

  task automatic rand_req();
    logic [31:0] imm;
    case ($urandom_range(0, 2))
      0:       imm = 32'(int'($urandom_range(0, 12287)) - 6144);
      1:       imm = $urandom;
      default: imm = 32'(int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21));
    endcase
    if ($urandom_range(0, 3) == 0) imm[11:0] = 12'h000;
    set_req(3'($urandom_range(0, 7)), imm, 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 3'($urandom));
  endtask

  // Drive one request into an empty pipeline with out_ready high; return what came out.
  task automatic send_one(output logic [31:0] w, output logic e, output int lat);
    int k;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    w = out_instr;
    e = out_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_req(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0 || err_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b w=%h e=%b cnt=%0d want 0 0 0 0", out_valid,
               out_instr, out_err, err_cnt);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_format(input string name, input logic [2:0] src, input logic [31:0] imm,
                             input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [31:0] want_w);
    logic [31:0] w;
    logic        e;
    int          lat;
    exp_t        x;
    x = model_enc(src, imm, op, rd, rs1, rs2, f3);
    set_req(src, imm, op, rd, rs1, rs2, f3);
    send_one(w, e, lat);
    exp_cnt = sat_inc(exp_cnt, x.e);
    n_vec++;
    if (w !== want_w || x.w !== want_w) begin
      n_err++;
      $display("FAIL %s_instr: got %h (model %h) want %h", name, w, x.w, want_w);
    end
    n_vec++;
    if (e !== x.e) begin
      n_err++;
      $display("FAIL %s_err: got %b want %b", name, e, x.e);
    end
    n_vec++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles want 2", name, lat);
    end
    n_vec++;
    if (err_cnt !== CW'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s_err_cnt: got %0d want %0d", name, err_cnt, exp_cnt);
    end
  endtask

  task automatic test_u_misaligned();
    logic [31:0] w;
    logic        e;
    int          lat;
    logic        want_e;
    int          cnt_before;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    want_e = 1'b1;
`else
    want_e = 1'b0;
`endif
    cnt_before = exp_cnt;
    set_req(3'd4, 32'h1234_5001, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0);
    send_one(w, e, lat);
    n_vec++;
    if (e !== want_e || w !== 32'h1234_50B7) begin
      n_err++;
      $display("FAIL u_misaligned: got w=%h e=%b want w=123450b7 e=%b", w, e, want_e);
    end
    exp_cnt = sat_inc(cnt_before, want_e);
    n_vec++;
    if (err_cnt !== CW'(exp_cnt)) begin
      n_err++;
      $display("FAIL u_misaligned_cnt: got %0d want %0d", err_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    exp_t        exp_q[3];
    logic [31:0] imms[3];
    int          idx;
    int          got;
    for (int i = 0; i < 3; i++) begin
      imms[i]  = 32'(int'($urandom_range(0, 4095)) - 2048);
      exp_q[i] = model_enc(3'd0, imms[i], 7'h13, 5'(i + 1), 5'(i + 7), 5'd0, 3'(i));
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 3);
      if (idx < 3) set_req(3'd0, imms[idx], 7'h13, 5'(idx + 1), 5'(idx + 7), 5'd0, 3'(idx));
      #1;
      if (c == 2) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_instr !== exp_q[0].w) begin
          n_err++;
          $display("FAIL bp_hold: got v=%b w=%h want v=1 w=%h", out_valid, out_instr,
                   exp_q[0].w);
        end
      end
      if (in_valid && in_ready) idx++;
    end
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 3);
      if (idx < 3) set_req(3'd0, imms[idx], 7'h13, 5'(idx + 1), 5'(idx + 7), 5'd0, 3'(idx));
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        n_vec++;
        if (out_instr !== exp_q[got].w || out_err !== exp_q[got].e) begin
          n_err++;
          $display("FAIL bp_order_%0d: got %h/%b want %h/%b", got, out_instr, out_err,
                   exp_q[got].w, exp_q[got].e);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (got != 3 || idx != 3) begin
      n_err++;
      $display("FAIL bp_count: got delivered=%0d accepted=%0d want 3 3", got, idx);
    end
  endtask

  task automatic test_random(input int ncyc);
    exp_t        q[$];
    exp_t        x;
    logic        pend;
    logic        stalled;
    logic [31:0] held_w;
    logic        held_e;
    int          k;
    pend    = 1'b0;
    stalled = 1'b0;
    held_w  = '0;
    held_e  = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      n_vec++;
      if (err_cnt !== CW'(exp_cnt)) begin
        n_err++;
        $display("FAIL rand_err_cnt @%0d: got %0d want %0d", c, err_cnt, exp_cnt);
      end
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_instr !== held_w || out_err !== held_e) begin
          n_err++;
          $display("FAIL rand_stall_hold @%0d: got %b/%h/%b want 1/%h/%b", c, out_valid,
                   out_instr, out_err, held_w, held_e);
        end
      end
      if (!pend) begin
        rand_req();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model_enc(in_imm_src, in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3));
        pend = 1'b0;
      end else begin
        pend = in_valid;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rand_spurious @%0d: got %h with empty scoreboard", c, out_instr);
        end else begin
          x = q.pop_front();
          if (out_instr !== x.w || out_err !== x.e) begin
            n_err++;
            $display("FAIL rand_word @%0d: got %h/%b want %h/%b", c, out_instr, out_err, x.w,
                     x.e);
          end
          exp_cnt = sat_inc(exp_cnt, x.e);
        end
      end
      stalled = out_valid && !out_ready;
      held_w  = out_instr;
      held_e  = out_err;
    end
    k = 0;
    while (q.size() != 0 && k < 10) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        x = q.pop_front();
        n_vec++;
        if (out_instr !== x.w || out_err !== x.e) begin
          n_err++;
          $display("FAIL rand_drain: got %h/%b want %h/%b", out_instr, out_err, x.w, x.e);
        end
        exp_cnt = sat_inc(exp_cnt, x.e);
      end
      k++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (q.size() != 0 || err_cnt !== CW'(exp_cnt)) begin
      n_err++;
      $display("FAIL rand_final: got pending=%0d cnt=%0d want 0 %0d", q.size(), err_cnt,
               exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic seen;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_req(3'($urandom_range(5, 7)), $urandom, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0);
      in_valid  = 1'b1;
      out_ready = (c == 2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || err_cnt !== '0 || out_instr !== 32'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b cnt=%0d w=%h rdy=%b want 0 0 0 1", out_valid, err_cnt,
               out_instr, in_ready);
    end
    exp_cnt  = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || err_cnt !== '0) begin
      n_err++;
      $display("FAIL mid_reset_flush: got out_valid seen=%b cnt=%0d want 0 0", seen, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_format("fmt_i", 3'd0, 32'hFFFF_FFFF, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFF3_0293);
    test_format("fmt_s", 3'd1, 32'd8, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'h0021_A423);
    test_format("fmt_b", 3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0063);
    test_format("fmt_u", 3'd4, 32'h1234_5000, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1234_50B7);
    test_format("fmt_rsv", 3'd6, 32'h0000_0010, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0000_0000);
    test_u_misaligned();
    test_backpressure();
    test_random(1500);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
